// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory access path: funct3 access-size
// codes, the access FSM state encoding, the default bus timeout, and helpers
// that decide legality and build store byte lanes.
// -----------------------------------------------------------------------------
package mem_pkg;

  // funct3 codes for loads/stores (size and signedness)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 256;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Legal = known size code for the direction, and address aligned to it.
  // Stores have no unsigned variants.
  function automatic logic is_legal(input logic is_store, input logic [2:0] f3,
                                    input logic [1:0] lane);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~lane[0];
      F3_W:    ok = (lane == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~lane[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store datum across every lane; byte enables pick the lane.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] wd;
    case (f3)
      F3_B:    wd = {4{data[7:0]}};
      F3_H:    wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// -----------------------------------------------------------------------------
// load_align_ext
// Combinational load extractor: picks the byte or halfword addressed by
// addr[1:0] out of the bus read word, then sign- or zero-extends it.
//   rdata  [31:0] in  : word returned by the data memory
//   addr   [1:0]  in  : byte offset of the access inside the word
//   funct3 [2:0]  in  : access size and signedness
//   data   [31:0] out : aligned, extended load result
// -----------------------------------------------------------------------------
module load_align_ext
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every variable gets a value before any branch, so no path can
    // leave one unassigned and infer a latch.
    byte_sel = rdata[7:0];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;

    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage data-memory interface. A legal load/store in the EX/MEM slot is
// launched onto a simple req/ack bus, the pipeline is stalled until the bus
// completes (or times out), and load data is aligned and extended.
//   clk, reset            : rising-edge clock, async active-high reset
//   valid_in              : EX/MEM slot holds a live instruction
//   mem_read_in/write_in  : instruction is a load / store
//   funct3_in             : access size and sign
//   alu_result_in         : byte address
//   store_data_in         : rs2 value for stores
//   dmem_req/we/addr/be/wdata (out), dmem_rdata/ack (in) : data bus
//   stall_out             : freeze PC, IF/ID, ID/EX and EX/MEM
//   mem_read_data_out     : load result towards MEM/WB
//   fault_out             : misaligned address or illegal funct3
//   bus_error_out         : one-cycle pulse when a transfer times out
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_out,
  output logic [31:0] mem_read_data_out,
  output logic        fault_out,
  output logic        bus_error_out
);

  // Counter value seen during the last permitted BUSY cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  busy_count;
  logic        access, legal;
  logic        ack_busy, timeout_hit;
  logic        load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [31:0] load_data;

  assign access      = valid_in & (mem_read_in | mem_write_in);
  assign legal       = is_legal(mem_write_in, funct3_in, alu_result_in[1:0]);
  // dmem_ack only means something while a request is outstanding.
  assign ack_busy    = (state == S_BUSY) & dmem_ack;
  assign timeout_hit = (state == S_BUSY) & ~dmem_ack & (busy_count == TIMEOUT_LAST);

  // Size and offset are captured at launch so extraction does not depend on
  // the pipeline holding EX/MEM perfectly still.
  load_align_ext u_align (
    .rdata  (dmem_rdata),
    .addr   (lane_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registered state uses non-blocking assignment so every flop
    // samples values from before the edge, independent of statement order.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next state, stall and fault
  always_comb begin
    state_next = state;
    stall_out  = 1'b0;
    fault_out  = 1'b0;
    case (state)
      S_IDLE: begin
        if (access && legal) begin
          stall_out  = 1'b1;
          state_next = S_BUSY;
        end else if (access) begin
          fault_out = 1'b1;
        end
      end
      S_BUSY: begin
        stall_out = 1'b1;
        if (ack_busy || timeout_hit) state_next = S_DONE;
      end
      // DONE lets the pipeline advance past the instruction still at the
      // inputs, so it is not launched a second time.
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Bus outputs, timeout counter and load result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_count        <= '0;
      dmem_req          <= 1'b0;
      dmem_we           <= 1'b0;
      dmem_addr         <= '0;
      dmem_be           <= '0;
      dmem_wdata        <= '0;
      mem_read_data_out <= '0;
      bus_error_out     <= 1'b0;
      load_q            <= 1'b0;
      funct3_q          <= '0;
      lane_q            <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          busy_count    <= '0;
          bus_error_out <= 1'b0;
          if (access && legal) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_in;
            dmem_addr  <= {alu_result_in[31:2], 2'b00};
            // Loads fetch the whole word; the extractor picks the lane.
            dmem_be    <= mem_write_in ? store_be(funct3_in, alu_result_in[1:0]) : 4'b1111;
            dmem_wdata <= store_wdata(funct3_in, store_data_in);
            load_q     <= ~mem_write_in;
            funct3_q   <= funct3_in;
            lane_q     <= alu_result_in[1:0];
          end
        end
        S_BUSY: begin
          if (ack_busy) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (load_q) mem_read_data_out <= load_data;
          end else if (timeout_hit) begin
            dmem_req          <= 1'b0;
            dmem_we           <= 1'b0;
            mem_read_data_out <= '0;
            bus_error_out     <= 1'b1;
          end else begin
            busy_count <= busy_count + 8'd1;
          end
        end
        default: bus_error_out <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed self-checking bench for mem_access_unit. The bench plays the data
// memory: it returns a chosen read word and raises ack after a chosen number
// of BUSY cycles. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, mem_read_in, mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_result_in, store_data_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        stall_out, fault_out, bus_error_out;
  logic [31:0] mem_read_data_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Results of the most recent access
  int          stalls;
  logic        unstable;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  mem_access_unit #(.TIMEOUT_CYCLES(256)) dut (
    .clk               (clk),
    .reset             (reset),
    .valid_in          (valid_in),
    .mem_read_in       (mem_read_in),
    .mem_write_in      (mem_write_in),
    .funct3_in         (funct3_in),
    .alu_result_in     (alu_result_in),
    .store_data_in     (store_data_in),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_be           (dmem_be),
    .dmem_wdata        (dmem_wdata),
    .dmem_rdata        (dmem_rdata),
    .dmem_ack          (dmem_ack),
    .stall_out         (stall_out),
    .mem_read_data_out (mem_read_data_out),
    .fault_out         (fault_out),
    .bus_error_out     (bus_error_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle_cycle();
    valid_in     = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    dmem_ack     = 1'b0;
    @(posedge clk); #1;
  endtask

  // Present one instruction and act as memory until stall drops. ack rises in
  // BUSY cycle number 'waits' (0 = first BUSY cycle). Leaves the instruction
  // at the inputs, with the DUT in DONE (or IDLE when nothing was launched).
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdata, input int waits);
    int busy;
    valid_in      = 1'b1;
    mem_read_in   = rd;
    mem_write_in  = wr;
    funct3_in     = f3;
    alu_result_in = addr;
    store_data_in = sdata;
    dmem_rdata    = rdata;
    dmem_ack      = 1'b0;
    stalls        = 0;
    unstable      = 1'b0;
    busy          = 0;
    cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
    #1;
    while (stall_out && stalls < 600) begin
      stalls++;
      if (dmem_req) begin
        if (busy == 0) begin
          cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_be = dmem_be; cap_we = dmem_we;
        end else if (dmem_addr !== cap_addr || dmem_wdata !== cap_wdata ||
                     dmem_be !== cap_be || dmem_we !== cap_we) begin
          unstable = 1'b1;
        end
        dmem_ack = (busy == waits);
        busy++;
      end
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    funct3_in = '0; alu_result_in = '0; store_data_in = '0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_req",   32'(dmem_req), 32'd0);
    check("rst_we",    32'(dmem_we), 32'd0);
    check("rst_be",    32'(dmem_be), 32'd0);
    check("rst_addr",  dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_rdout", mem_read_data_out, 32'd0);
    check("rst_berr",  32'(bus_error_out), 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Non-access instruction passes straight through
    valid_in = 1'b1; #1;
    check("nop_stall", 32'(stall_out), 32'd0);
    check("nop_fault", 32'(fault_out), 32'd0);
    @(posedge clk); #1;
    check("nop_req", 32'(dmem_req), 32'd0);

    // Stray ack in IDLE is ignored
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    check("idle_ack_req",   32'(dmem_req), 32'd0);
    check("idle_ack_rdout", mem_read_data_out, 32'd0);
    idle_cycle();

    // LW 0x100, zero wait states
    do_access(1'b1, 1'b0, F3_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    check("lw_stalls", 32'(stalls), 32'd2);
    check("lw_addr",   cap_addr, 32'h100);
    check("lw_be",     32'(cap_be), 32'hF);
    check("lw_we",     32'(cap_we), 32'd0);
    check("lw_data",   mem_read_data_out, 32'hDEAD_BEEF);
    check("lw_req_done", 32'(dmem_req), 32'd0);
    idle_cycle();
    check("lw_idle_stall", 32'(stall_out), 32'd0);

    // LB / LBU at 0x103
    do_access(1'b1, 1'b0, F3_B, 32'h103, 32'h0, 32'h8000_0000, 0);
    check("lb_data", mem_read_data_out, 32'hFFFF_FF80);
    check("lb_addr", cap_addr, 32'h100);
    idle_cycle();
    do_access(1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 32'h8000_0000, 0);
    check("lbu_data", mem_read_data_out, 32'h0000_0080);
    idle_cycle();

    // SH at 0x102 with three wait cycles; load result must not change
    do_access(1'b0, 1'b1, F3_H, 32'h102, 32'h1234_ABCD, 32'hFFFF_FFFF, 3);
    check("sh_stalls",   32'(stalls), 32'd5);
    check("sh_be",       32'(cap_be), 32'hC);
    check("sh_wdata",    cap_wdata, 32'hABCD_ABCD);
    check("sh_we",       32'(cap_we), 32'd1);
    check("sh_addr",     cap_addr, 32'h100);
    check("sh_stable",   32'(unstable), 32'd0);
    check("sh_keep_rd",  mem_read_data_out, 32'h0000_0080);
    idle_cycle();

    // SB at 0x101
    do_access(1'b0, 1'b1, F3_B, 32'h101, 32'h0000_00EF, 32'h0, 0);
    check("sb_be",    32'(cap_be), 32'h2);
    check("sb_wdata", cap_wdata, 32'hEFEF_EFEF);
    idle_cycle();

    // LH / LHU
    do_access(1'b1, 1'b0, F3_H, 32'h102, 32'h0, 32'h8001_0000, 0);
    check("lh_data", mem_read_data_out, 32'hFFFF_8001);
    idle_cycle();
    do_access(1'b1, 1'b0, F3_HU, 32'h100, 32'h0, 32'h1234_F00D, 0);
    check("lhu_data", mem_read_data_out, 32'h0000_F00D);
    idle_cycle();

    // Misaligned LW: fault, no request, no stall
    do_access(1'b1, 1'b0, F3_W, 32'h101, 32'h0, 32'h0, 0);
    check("mis_stall", 32'(stalls), 32'd0);
    check("mis_fault", 32'(fault_out), 32'd1);
    @(posedge clk); #1;
    check("mis_req",   32'(dmem_req), 32'd0);
    idle_cycle();
    check("mis_fault_clr", 32'(fault_out), 32'd0);

    // Illegal funct3 for a load, and an unsigned store code
    do_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    check("f3_load_fault", 32'(fault_out), 32'd1);
    idle_cycle();
    do_access(1'b0, 1'b1, F3_BU, 32'h100, 32'h0, 32'h0, 0);
    check("f3_store_fault", 32'(fault_out), 32'd1);
    check("f3_store_stall", 32'(stalls), 32'd0);
    idle_cycle();

    // Ack on the 256th BUSY cycle wins over the timeout
    do_access(1'b1, 1'b0, F3_W, 32'h0, 32'h0, 32'h5A5A_5A5A, 255);
    check("ackwin_stalls", 32'(stalls), 32'd257);
    check("ackwin_berr",   32'(bus_error_out), 32'd0);
    check("ackwin_data",   mem_read_data_out, 32'h5A5A_5A5A);
    idle_cycle();

    // No ack at all: timeout after 256 BUSY cycles
    do_access(1'b1, 1'b0, F3_W, 32'h4, 32'h0, 32'h7777_7777, 1000);
    check("to_stalls", 32'(stalls), 32'd257);
    check("to_berr",   32'(bus_error_out), 32'd1);
    check("to_data",   mem_read_data_out, 32'd0);
    check("to_req",    32'(dmem_req), 32'd0);
    idle_cycle();
    check("to_berr_pulse", 32'(bus_error_out), 32'd0);

    // Reset while BUSY abandons the transfer at once
    valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
    funct3_in = F3_W; alu_result_in = 32'h200; dmem_ack = 1'b0;
    @(posedge clk); #1;
    check("rb_req_busy", 32'(dmem_req), 32'd1);
    reset = 1'b1; #1;
    check("rb_req_async", 32'(dmem_req), 32'd0);
    check("rb_be_async",  32'(dmem_be), 32'd0);
    check("rb_addr_async", dmem_addr, 32'd0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rb_idle_stall", 32'(stall_out), 32'd0);
    do_access(1'b1, 1'b0, F3_W, 32'h200, 32'h0, 32'hCAFE_F00D, 1);
    check("rb_lw_stalls", 32'(stalls), 32'd3);
    check("rb_lw_data",   mem_read_data_out, 32'hCAFE_F00D);
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, with clock and reset named as in the rest of the codebase.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, the maximum number of BUSY cycles without dmem_ack.
REQ-003 SHALL have ports, listed as name, direction, width, meaning:
- clk, in, 1, rising-edge clock.
- reset, in, 1, asynchronous active-high reset.
- valid_in, in, 1, EX/MEM slot holds a live instruction.
- mem_read_in, in, 1, the instruction is a load.
- mem_write_in, in, 1, the instruction is a store.
- funct3_in, in, 3, access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- alu_result_in, in, 32, byte address.
- store_data_in, in, 32, rs2 value.
- dmem_req, out, 1, bus request.
- dmem_we, out, 1, write strobe.
- dmem_addr, out, 32, word-aligned address: alu_result_in with bits [1:0] forced to 0.
- dmem_be, out, 4, byte enables.
- dmem_wdata, out, 32, lane-replicated store data.
- dmem_rdata, in, 32, read word.
- dmem_ack, in, 1, transfer complete.
- stall_out, out, 1, hold the PC, IF/ID, ID/EX and EX/MEM stages.
- mem_read_data_out, out, 32, aligned and extended load data, fed to MEM_WB.
- fault_out, out, 1, misaligned address or illegal funct3.
- bus_error_out, out, 1, timeout pulse.

Function
REQ-004 SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-005 An access SHALL be defined as valid_in & (mem_read_in | mem_write_in).
REQ-006 A legal access SHALL be an access with a legal funct3 and correct alignment: H/HU require addr[0]=0, W requires addr[1:0]=0, and stores accept only 000, 001 and 010.
REQ-007 In IDLE, a legal access SHALL cause a transition to BUSY on the next edge and register dmem_addr, dmem_we, dmem_be and dmem_wdata, with dmem_req=1.
REQ-008 In IDLE, an illegal access SHALL assert fault_out combinationally, issue no request and not stall.
REQ-009 A non-access instruction in IDLE SHALL pass through with no stall.
REQ-010 stall_out SHALL be combinational: 1 when (IDLE & legal access) or BUSY, and 0 in DONE.
REQ-011 In BUSY, all dmem_* outputs SHALL hold stable until dmem_ack=1.
REQ-012 On ack, the FSM SHALL drop dmem_req at the next edge, go to DONE, and for a load capture extracted data into mem_read_data_out.
REQ-013 The FSM SHALL go from DONE to IDLE unconditionally; DONE prevents re-issuing the instruction still present at the inputs.
REQ-014 With a zero-wait-state memory (ack in the first BUSY cycle), a load SHALL cost exactly 2 stall cycles.
REQ-015 Store lanes SHALL be formed as follows:
- SB: be = 1<<addr[1:0], wdata = {4{byte}}.
- SH: be = addr[1] ? 1100 : 0011, wdata = {2{half}}.
- SW: be = 1111.
REQ-016 Load extraction SHALL select the byte or half by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-017 mem_read_data_out SHALL hold its value until the next load completes; stores SHALL not change it.
REQ-018 An 8-bit counter SHALL count BUSY cycles; if TIMEOUT_CYCLES BUSY cycles elapse without ack, the FSM SHALL go to DONE, force mem_read_data_out=0 and assert bus_error_out for the DONE cycle only.
REQ-019 If ack coincides with the final timeout cycle, ack SHALL win and no error is flagged.
REQ-020 dmem_ack SHALL be ignored outside BUSY.

Reset
REQ-021 Reset SHALL asynchronously force state=IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, mem_read_data_out=0 and bus_error_out=0.
REQ-022 Reset asserted in BUSY SHALL abandon the transaction, dropping dmem_req immediately.
REQ-023 After reset is released, the first edge SHALL evaluate from IDLE.

Structure
REQ-024 Shared package mem_pkg SHALL hold the funct3 constants, the FSM state encoding and the TIMEOUT_CYCLES default.
REQ-025 Load extraction SHALL be a combinational sub-module, load_align_ext, with inputs rdata, addr[1:0] and funct3 and output data[31:0].

Verification
REQ-026 Directed scenario, LW: LW at 0x100, rdata 0xDEADBEEF, ack in the first BUSY cycle -> stall high 2 cycles, mem_read_data_out=0xDEADBEEF in DONE.
REQ-027 Directed scenario, LB/LBU: LB at 0x103, rdata 0x80000000 -> 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-028 Directed scenario, SH: SH at 0x102, rs2 0x1234ABCD -> be=1100, wdata=0xABCDABCD, we=1, outputs stable through 3 wait cycles.
REQ-029 Directed scenario, misaligned LW: LW at 0x101 -> fault_out=1, dmem_req never asserted, stall_out=0.
REQ-030 Directed scenario, timeout and ack-wins: no ack -> DONE after 256 BUSY cycles with bus_error_out=1 for 1 cycle and data 0; ack on cycle 256 -> no error.
REQ-031 Directed scenario, reset mid-BUSY: reset asserted in BUSY -> dmem_req=0 immediately, state IDLE; a subsequent LW completes normally.
